// File: rtl/demod_pkg.sv
// Shared types and default parameters for the shot-based IQ demod integrator.
package demod_pkg;

    localparam int DEF_LANES    = 5;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_LEN_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_INTEG = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Width that holds the exact signed sum of all lanes of one clock.
    function automatic int sum_width(input int lanes, input int sample_w);
        return sample_w + $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/lane_sum.sv
// Combinational signed sum of all lanes of one packed sample vector.
module lane_sum
    import demod_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int OUT_W    = sum_width(LANES, SAMPLE_W)
) (
    input  logic [LANES*SAMPLE_W-1:0] data,
    output logic signed [OUT_W-1:0]   sum
);

    logic signed [OUT_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < LANES; k++) begin
            acc = acc + OUT_W'(signed'(data[k*SAMPLE_W +: SAMPLE_W]));
        end
        sum = acc;
    end

endmodule

// File: rtl/demod_integrator.sv
// Triggered delay/integrate engine over LANES-wide I/Q samples with
// saturating accumulators and a latched threshold decision.
module demod_integrator
    import demod_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trigger,
    input  logic                      in_valid,
    input  logic [LANES*SAMPLE_W-1:0] i_data,
    input  logic [LANES*SAMPLE_W-1:0] q_data,
    input  logic [LEN_W-1:0]          cfg_delay,
    input  logic [LEN_W-1:0]          cfg_length,
    input  logic signed [ACC_W-1:0]   cfg_threshold,
    output logic                      iq_valid,
    output logic signed [ACC_W-1:0]   i_val,
    output logic signed [ACC_W-1:0]   q_val,
    output logic                      state_bit,
    output logic                      overflow,
    output logic                      busy,
    output logic                      missed_trig
);

    localparam int SUM_W = sum_width(LANES, SAMPLE_W);
    localparam int ADD_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_e state_q, state_d;

    logic                    trig_prev_q, trig_prev_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic signed [ACC_W-1:0] thr_q, thr_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] i_val_q, i_val_d;
    logic signed [ACC_W-1:0] q_val_q, q_val_d;
    logic                    state_bit_q, state_bit_d;
    logic                    overflow_q, overflow_d;
    logic                    iq_valid_q, iq_valid_d;
    logic                    missed_q, missed_d;

    logic                    trig_edge;
    logic signed [SUM_W-1:0] sum_i, sum_q;
    logic [ACC_W:0]          add_i, add_q;

    lane_sum #(
        .LANES    (LANES),
        .SAMPLE_W (SAMPLE_W),
        .OUT_W    (SUM_W)
    ) u_sum_i (
        .data (i_data),
        .sum  (sum_i)
    );

    lane_sum #(
        .LANES    (LANES),
        .SAMPLE_W (SAMPLE_W),
        .OUT_W    (SUM_W)
    ) u_sum_q (
        .data (q_data),
        .sum  (sum_q)
    );

    // Returns {saturated, value}; the add is done wide enough that the
    // lane sum never wraps even when ACC_W is narrower than SUM_W.
    function automatic logic [ACC_W:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [SUM_W-1:0] b
    );
        logic signed [ADD_W-1:0] ax, bx, sx, mx, nx;
        logic [ACC_W:0]          r;
        ax = {{(ADD_W-ACC_W){a[ACC_W-1]}}, a};
        bx = {{(ADD_W-SUM_W){b[SUM_W-1]}}, b};
        sx = ax + bx;
        mx = {{(ADD_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
        nx = {{(ADD_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
        if (sx > mx) begin
            r = {1'b1, mx[ACC_W-1:0]};
        end else if (sx < nx) begin
            r = {1'b1, nx[ACC_W-1:0]};
        end else begin
            r = {1'b0, sx[ACC_W-1:0]};
        end
        return r;
    endfunction

    assign trig_edge   = trigger & ~trig_prev_q;
    assign trig_prev_d = trigger;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trig_edge) begin
                    if (cfg_delay != '0) begin
                        state_d = ST_DELAY;
                    end else if (cfg_length != '0) begin
                        state_d = ST_INTEG;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DELAY: begin
                if (in_valid && cnt_q == ONE) begin
                    state_d = (len_q != '0) ? ST_INTEG : ST_DONE;
                end
            end
            ST_INTEG: begin
                if (in_valid && cnt_q == ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        add_i   = sat_add(acc_i_q, sum_i);
        add_q   = sat_add(acc_q_q, sum_q);
        cnt_d   = cnt_q;
        len_d   = len_q;
        thr_d   = thr_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trig_edge) begin
                    len_d   = cfg_length;
                    thr_d   = cfg_threshold;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = (cfg_delay != '0) ? cfg_delay : cfg_length;
                end
            end
            ST_DELAY: begin
                if (in_valid) begin
                    cnt_d = (cnt_q == ONE) ? len_q : cnt_q - ONE;
                end
            end
            ST_INTEG: begin
                if (in_valid) begin
                    cnt_d   = cnt_q - ONE;
                    acc_i_d = add_i[ACC_W-1:0];
                    acc_q_d = add_q[ACC_W-1:0];
                    ovf_d   = ovf_q | add_i[ACC_W] | add_q[ACC_W];
                end
            end
            default: ;
        endcase
    end

    // Result registers load on entry to DONE so they are valid with the strobe.
    always_comb begin
        i_val_d     = i_val_q;
        q_val_d     = q_val_q;
        state_bit_d = state_bit_q;
        overflow_d  = overflow_q;
        iq_valid_d  = 1'b0;
        if (state_d == ST_DONE) begin
            i_val_d     = acc_i_d;
            q_val_d     = acc_q_d;
            state_bit_d = (acc_i_d >= thr_d);
            overflow_d  = ovf_d;
            iq_valid_d  = 1'b1;
        end
        missed_d = trig_edge && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev_q <= 1'b1;
            cnt_q       <= '0;
            len_q       <= '0;
            thr_q       <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            ovf_q       <= 1'b0;
            i_val_q     <= '0;
            q_val_q     <= '0;
            state_bit_q <= 1'b0;
            overflow_q  <= 1'b0;
            iq_valid_q  <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            trig_prev_q <= trig_prev_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            thr_q       <= thr_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            ovf_q       <= ovf_d;
            i_val_q     <= i_val_d;
            q_val_q     <= q_val_d;
            state_bit_q <= state_bit_d;
            overflow_q  <= overflow_d;
            iq_valid_q  <= iq_valid_d;
            missed_q    <= missed_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign iq_valid    = iq_valid_q;
    assign i_val       = i_val_q;
    assign q_val       = q_val_q;
    assign state_bit   = state_bit_q;
    assign overflow    = overflow_q;
    assign missed_trig = missed_q;

endmodule

// File: tb/tb_demod_integrator.sv
// Bench: table-driven shots, hand corner sequences and a random run,
// all shadowed by a shot-level reference model on 32- and 16-bit builds.
module tb_demod_integrator;

    localparam int LANES = 5;
    localparam int SW    = 16;
    localparam int LW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst = 1'b1;
    logic                    trigger = 1'b0;
    logic                    in_valid = 1'b0;
    logic [LANES*SW-1:0]     i_data, q_data;
    logic [LW-1:0]           cfg_delay = '0;
    logic [LW-1:0]           cfg_length = '0;
    logic signed [31:0]      cfg_threshold = '0;
    logic signed [15:0]      thr16;
    int                      ilane[LANES];
    int                      qlane[LANES];

    logic                    iq_valid, state_bit, overflow, busy, missed_trig;
    logic signed [31:0]      i_val, q_val;
    logic                    iq16, sb16, ovf16, busy16, miss16;
    logic signed [15:0]      i16, q16;

    assign thr16 = cfg_threshold[15:0];

    always_comb begin
        i_data = '0;
        q_data = '0;
        for (int k = 0; k < LANES; k++) begin
            i_data[k*SW +: SW] = SW'(ilane[k]);
            q_data[k*SW +: SW] = SW'(qlane[k]);
        end
    end

    demod_integrator dut (
        .clk(clk), .rst(rst), .trigger(trigger), .in_valid(in_valid),
        .i_data(i_data), .q_data(q_data),
        .cfg_delay(cfg_delay), .cfg_length(cfg_length),
        .cfg_threshold(cfg_threshold),
        .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val),
        .state_bit(state_bit), .overflow(overflow),
        .busy(busy), .missed_trig(missed_trig)
    );

    demod_integrator #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .trigger(trigger), .in_valid(in_valid),
        .i_data(i_data), .q_data(q_data),
        .cfg_delay(cfg_delay), .cfg_length(cfg_length),
        .cfg_threshold(thr16),
        .iq_valid(iq16), .i_val(i16), .q_val(q16),
        .state_bit(sb16), .overflow(ovf16),
        .busy(busy16), .missed_trig(miss16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model (shot level) ----------------
    bit     m_active = 0, m_strobe = 0, m_prev = 1, m_edge;
    int     m_skip = 0, m_len = 0;
    longint m_thr = 0, m_thr16 = 0, m_si, m_sq;
    longint a_i = 0, a_q = 0, a_i16 = 0, a_q16 = 0;
    bit     m_ovf = 0, m_ovf16 = 0;
    bit     e_iq = 0, e_miss = 0, e_busy = 0;
    bit     e_sb = 0, e_ovf = 0, e_sb16 = 0, e_ovf16 = 0;
    longint e_i = 0, e_q = 0, e_i16 = 0, e_q16 = 0;

    function automatic longint lim(input int w, input bit hi);
        longint p;
        p = longint'(1) << (w - 1);
        return hi ? p - 1 : -p;
    endfunction

    task automatic acc_step(inout longint a, inout bit ov,
                            input longint s, input int w);
        longint t;
        t = a + s;
        if (t > lim(w, 1'b1)) begin
            t  = lim(w, 1'b1);
            ov = 1'b1;
        end else if (t < lim(w, 1'b0)) begin
            t  = lim(w, 1'b0);
            ov = 1'b1;
        end
        a = t;
    endtask

    task automatic m_finish();
        e_i     = a_i;
        e_q     = a_q;
        e_sb    = (a_i >= m_thr);
        e_ovf   = m_ovf;
        e_i16   = a_i16;
        e_q16   = a_q16;
        e_sb16  = (a_i16 >= m_thr16);
        e_ovf16 = m_ovf16;
        e_iq    = 1'b1;
        m_strobe = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_strobe = 0; m_prev = 1;
            m_skip = 0; m_len = 0;
            e_iq = 0; e_miss = 0; e_busy = 0;
            e_i = 0; e_q = 0; e_sb = 0; e_ovf = 0;
            e_i16 = 0; e_q16 = 0; e_sb16 = 0; e_ovf16 = 0;
        end else begin
            m_edge = trigger && !m_prev;
            m_prev = trigger;
            e_iq   = 0;
            e_miss = 0;
            m_si = 0;
            m_sq = 0;
            for (int k = 0; k < LANES; k++) begin
                m_si += ilane[k];
                m_sq += qlane[k];
            end
            if (m_strobe) begin
                e_miss   = m_edge;
                m_strobe = 0;
                m_active = 0;
            end else if (m_active) begin
                e_miss = m_edge;
                if (in_valid) begin
                    if (m_skip > 0) begin
                        m_skip--;
                    end else begin
                        acc_step(a_i, m_ovf, m_si, 32);
                        acc_step(a_q, m_ovf, m_sq, 32);
                        acc_step(a_i16, m_ovf16, m_si, 16);
                        acc_step(a_q16, m_ovf16, m_sq, 16);
                        m_len--;
                    end
                    if (m_skip == 0 && m_len == 0) m_finish();
                end
            end else if (m_edge) begin
                m_active = 1;
                m_skip   = int'(cfg_delay);
                m_len    = int'(cfg_length);
                m_thr    = longint'(cfg_threshold);
                m_thr16  = longint'(thr16);
                a_i = 0; a_q = 0; a_i16 = 0; a_q16 = 0;
                m_ovf = 0; m_ovf16 = 0;
                if (m_skip == 0 && m_len == 0) m_finish();
            end
            e_busy = m_active;
        end
    end

    always @(negedge clk) begin
        chk("iq_valid", longint'(iq_valid), longint'(e_iq));
        chk("i_val", longint'(i_val), e_i);
        chk("q_val", longint'(q_val), e_q);
        chk("state_bit", longint'(state_bit), longint'(e_sb));
        chk("overflow", longint'(overflow), longint'(e_ovf));
        chk("busy", longint'(busy), longint'(e_busy));
        chk("missed_trig", longint'(missed_trig), longint'(e_miss));
        chk("iq_valid16", longint'(iq16), longint'(e_iq));
        chk("i_val16", longint'(i16), e_i16);
        chk("q_val16", longint'(q16), e_q16);
        chk("state_bit16", longint'(sb16), longint'(e_sb16));
        chk("overflow16", longint'(ovf16), longint'(e_ovf16));
        chk("busy16", longint'(busy16), longint'(e_busy));
        chk("missed16", longint'(miss16), longint'(e_miss));
    end

    // ---------------- directed table ----------------
    typedef struct {
        int     d;
        int     l;
        longint thr;
        int     iv;
        int     qv;
        bit     alt;
        int     lat;
        longint ei;
        longint eq;
        bit     esb;
        bit     eovf;
        longint ei16;
        longint eq16;
        bit     esb16;
        bit     eovf16;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lanes(input int iv, input int qv);
        for (int k = 0; k < LANES; k++) begin
            ilane[k] = iv;
            qlane[k] = qv;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit     got;
        int     lat;
        longint gi, gq, gi16, gq16;
        bit     gsb, govf, gsb16, govf16;
        got = 0; lat = -1;
        gi = 0; gq = 0; gi16 = 0; gq16 = 0;
        gsb = 0; govf = 0; gsb16 = 0; govf16 = 0;
        cfg_delay     = LW'(v.d);
        cfg_length    = LW'(v.l);
        cfg_threshold = 32'(v.thr);
        set_lanes(v.iv, v.qv);
        trigger  = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            trigger       = 1'b0;
            cfg_delay     = LW'($urandom);
            cfg_length    = LW'($urandom);
            cfg_threshold = $urandom;
            in_valid      = v.alt ? ((k % 2) == 0) : 1'b1;
            @(negedge clk);
            if (iq_valid) begin
                got  = 1;
                lat  = k;
                gi   = longint'(i_val);
                gq   = longint'(q_val);
                gsb  = state_bit;
                govf = overflow;
                gi16 = longint'(i16);
                gq16 = longint'(q16);
                gsb16  = sb16;
                govf16 = ovf16;
            end
        end
        in_valid = 1'b0;
        if (!got) begin
            chk($sformatf("v%0d_strobe_timeout", idx), 0, 1);
        end else begin
            chk($sformatf("v%0d_latency", idx), lat, v.lat);
            chk($sformatf("v%0d_i", idx), gi, v.ei);
            chk($sformatf("v%0d_q", idx), gq, v.eq);
            chk($sformatf("v%0d_sb", idx), gsb, v.esb);
            chk($sformatf("v%0d_ovf", idx), govf, v.eovf);
            chk($sformatf("v%0d_i16", idx), gi16, v.ei16);
            chk($sformatf("v%0d_q16", idx), gq16, v.eq16);
            chk($sformatf("v%0d_sb16", idx), gsb16, v.esb16);
            chk($sformatf("v%0d_ovf16", idx), govf16, v.eovf16);
        end
        step();
        step();
    endtask

    bit trg[8]   = '{1, 0, 1, 0, 1, 1, 0, 0};
    bit exp_m[8] = '{0, 0, 1, 0, 1, 0, 0, 0};
    bit exp_v[8] = '{0, 0, 0, 1, 0, 0, 0, 0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int     nseen, nbusy, npulse;
        longint ci, cq;

        tbl[0] = '{2, 3, 0, 1, -2, 0, 5, 15, -30, 1, 0, 15, -30, 1, 0};
        tbl[1] = '{2, 3, 0, 1, -2, 1, 9, 15, -30, 1, 0, 15, -30, 1, 0};
        tbl[2] = '{0, 4, 0, 32767, 0, 0, 4, 655340, 0, 1, 0, 32767, 0, 1, 1};
        tbl[3] = '{1, 2, 100, 3, -1, 0, 3, 30, -10, 0, 0, 30, -10, 0, 0};
        tbl[4] = '{0, 0, 0, 5, 5, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        tbl[5] = '{0, 1, -35, -7, 5, 0, 1, -35, 25, 1, 0, -35, 25, 1, 0};
        tbl[6] = '{0, 1, -34, -7, 5, 0, 1, -35, 25, 0, 0, -35, 25, 0, 0};
        tbl[7] = '{3, 1, 0, -32768, 32767, 0, 4,
                   -163840, 163835, 0, 0, -32768, 32767, 0, 1};

        set_lanes(0, 0);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        for (int n = 0; n < 8; n++) run_vec(tbl[n], n);

        // second edge during INTEG and during DONE
        cfg_delay = LW'(0);
        cfg_length = LW'(3);
        cfg_threshold = 0;
        set_lanes(2, 1);
        in_valid = 1'b0;
        trigger  = trg[0];
        npulse = 0; ci = 0; cq = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            trigger  = (k < 7) ? trg[k+1] : 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("mt_missed_k%0d", k), missed_trig, exp_m[k]);
            chk($sformatf("mt_iq_k%0d", k), iq_valid, exp_v[k]);
            if (iq_valid) begin
                npulse++;
                ci = longint'(i_val);
                cq = longint'(q_val);
            end
        end
        trigger = 1'b0;
        in_valid = 1'b0;
        chk("mt_strobes", npulse, 1);
        chk("mt_i", ci, 30);
        chk("mt_q", cq, 15);
        step();

        // reset mid-INTEG, trigger held high across reset
        cfg_delay = LW'(1);
        cfg_length = LW'(6);
        set_lanes(4, 4);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        in_valid = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        trigger = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_iq", iq_valid, 0);
        chk("rst_i", longint'(i_val), 0);
        chk("rst_q", longint'(q_val), 0);
        chk("rst_sb", state_bit, 0);
        chk("rst_ovf", overflow, 0);
        step();
        rst = 1'b0;
        nseen = 0;
        nbusy = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 4) trigger = 1'b0;
            @(negedge clk);
            if (iq_valid) nseen++;
            if (busy) nbusy++;
        end
        in_valid = 1'b0;
        chk("rst_no_strobe", nseen, 0);
        chk("rst_held_trig_idle", nbusy, 0);
        run_vec(tbl[3], 30);
        run_vec(tbl[0], 31);

        // randomized traffic shadowed by the model
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int k = 0; k < LANES; k++) begin
                ilane[k] = int'($urandom_range(0, 65535)) - 32768;
                qlane[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) trigger = ~trigger;
            cfg_delay     = LW'($urandom_range(0, 4));
            cfg_length    = LW'($urandom_range(0, 6));
            cfg_threshold = 32'(int'($urandom_range(0, 2000)) - 1000);
            rst           = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        trigger = 1'b0;
        in_valid = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
